// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared constants, LED bit indices, key-event layout and FSM
// state encoding for the PS/2 keyboard LED controller.
//
// Contents:
//   PS2_CMD_SET_LED  keyboard "set LEDs" command byte (8'hED)
//   PS2_ACK          keyboard acknowledge byte (8'hFA)
//   PS2_RESEND       keyboard resend request byte (8'hFE)
//   KEY_CAPS         decoded character code of Caps Lock (8'd20)
//   LED_*            bit positions inside the {caps, num, scroll} LED vector
//   key_evt_t        decoded key event {released, char_code}
//   ps2_state_e      controller FSM states
//   is_caps_press()  true for a Caps Lock make (press) event
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;
  localparam logic [7:0] KEY_CAPS        = 8'd20;

  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;
  localparam int LED_W      = 3;

  typedef struct packed {
    logic       released;
    logic [7:0] char_code;
  } key_evt_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_ACK1 = 3'd2,
    SEND_LED  = 3'd3,
    WAIT_ACK2 = 3'd4
  } ps2_state_e;

  function automatic logic is_caps_press(input key_evt_t evt);
    return !evt.released && (evt.char_code == KEY_CAPS);
  endfunction

endpackage

// File: rtl/ps2_timeout.sv
// ps2_timeout -- response watchdog for the PS/2 LED controller.
//
// Counts enabled cycles since the last clear. expired is high while enabled
// and the count sits at TIMEOUT_CYCLES-1; the count saturates there so a
// late consumer still sees expiry on the following cycle.
//
// Ports:
//   clk      in   system clock, posedge
//   rst      in   synchronous active-high reset
//   clear    in   force count to zero
//   enable   in   count this cycle
//   expired  out  count has reached TIMEOUT_CYCLES-1 (while enabled)
module ps2_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl -- keeps the keyboard's LEDs in sync with a local target.
//
// A Caps Lock press toggles the caps bit of the target; a CPU write loads
// the whole target (and wins over a same-cycle Caps press). Any target
// update marks the target pending; from IDLE the FSM then sends 8'hED,
// waits for 8'hFA, sends the LED byte, waits for 8'hFA and commits the
// sent value to leds. A missing ack (timeout) or a rejected byte raises a
// one-cycle err and returns to IDLE with leds unchanged.
//
// Optional feature (compile-time macro PS2_LED_RESEND_EN):
//   defined   -> 8'hFE re-sends the byte just sent, up to MAX_RETRY times;
//                the next 8'hFE after that raises err.
//   undefined -> 8'hFE raises err immediately; no retry counter exists.
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   synchronous active-high reset
//   key_valid  in   decoded key event strobe
//   key_code   in   {released, char}
//   rx_valid   in   received-byte strobe
//   rx_data    in   received byte
//   tx_ready   in   transmitter can accept a byte
//   tx_start   out  one-cycle transmit strobe
//   tx_data    out  byte to transmit
//   cpu_wr     in   CPU LED write strobe
//   cpu_leds   in   CPU LED value {caps, num, scroll}
//   leds       out  LED state last acknowledged by the keyboard
//   busy       out  FSM not in IDLE
//   err        out  one-cycle error pulse
module ps2_led_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [8:0]       key_code,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             cpu_wr,
  input  logic [LED_W-1:0] cpu_leds,
  output logic [LED_W-1:0] leds,
  output logic             busy,
  output logic             err
);

  ps2_state_e       state;
  logic [LED_W-1:0] target;
  logic [LED_W-1:0] snapshot;
  logic             pending;

  key_evt_t         evt;
  logic [LED_W-1:0] target_nxt;
  logic             target_upd;

  logic             waiting;
  logic             to_expired;

`ifdef PS2_LED_RESEND_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry;
`else
  // MAX_RETRY only shapes the resend logic, which is absent in this build.
  logic unused_max_retry;
  assign unused_max_retry = ^32'(MAX_RETRY);
`endif

  assign evt  = key_evt_t'(key_code);
  assign busy = (state != IDLE);

  // Target update: CPU write has priority, so a same-cycle Caps toggle is lost.
  always_comb begin
    target_nxt = target;
    target_upd = 1'b0;
    if (cpu_wr) begin
      target_nxt = cpu_leds;
      target_upd = 1'b1;
    end else if (key_valid && is_caps_press(evt)) begin
      target_nxt[LED_CAPS] = ~target[LED_CAPS];
      target_upd = 1'b1;
    end
  end

  // The watchdog is held clear outside the wait states, so every entry into
  // a wait state starts counting from zero.
  assign waiting = (state == WAIT_ACK1) || (state == WAIT_ACK2);

  ps2_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting),
    .enable (waiting),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target   <= '0;
      snapshot <= '0;
      leds     <= '0;
      pending  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      err      <= 1'b0;
`ifdef PS2_LED_RESEND_EN
      retry    <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      err      <= 1'b0;
      target   <= target_nxt;

      // A fresh update beats the clear so a change racing the IDLE exit
      // still schedules another sequence.
      if (target_upd) begin
        pending <= 1'b1;
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
`ifdef PS2_LED_RESEND_EN
          retry <= '0;
`endif
          if (pending) state <= SEND_CMD;
        end

        SEND_CMD: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= PS2_CMD_SET_LED;
            state    <= WAIT_ACK1;
          end
        end

        SEND_LED: begin
          if (tx_ready) begin
            snapshot <= target;
            tx_start <= 1'b1;
            tx_data  <= {5'b0, target};
            state    <= WAIT_ACK2;
          end
        end

        WAIT_ACK1, WAIT_ACK2: begin
          // Any received byte is handled ahead of a same-cycle timeout;
          // bytes that are neither ack nor resend are simply dropped.
          if (rx_valid) begin
            if (rx_data == PS2_ACK) begin
`ifdef PS2_LED_RESEND_EN
              // Retry budget is per byte: an ack refills it.
              retry <= '0;
`endif
              if (state == WAIT_ACK1) begin
                state <= SEND_LED;
              end else begin
                leds  <= snapshot;
                state <= IDLE;
              end
            end else if (rx_data == PS2_RESEND) begin
`ifdef PS2_LED_RESEND_EN
              if (retry == RW'(MAX_RETRY)) begin
                err   <= 1'b1;
                state <= IDLE;
              end else begin
                retry <= retry + 1'b1;
                state <= (state == WAIT_ACK1) ? SEND_CMD : SEND_LED;
              end
`else
              err   <= 1'b1;
              state <= IDLE;
`endif
            end
          end else if (to_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// tb_ps2_led_ctrl -- directed self-checking bench for ps2_led_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge; every
// helper task starts and ends on a falling edge.
module tb_ps2_led_ctrl;

  localparam int TO = 100;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [8:0] key_code;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       cpu_wr;
  logic [2:0] cpu_leds;
  logic [2:0] leds;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ps2_led_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .cpu_wr   (cpu_wr),
    .cpu_leds (cpu_leds),
    .leds     (leds),
    .busy     (busy),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [8:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic cpu(input logic [2:0] v);
    cpu_wr   = 1'b1;
    cpu_leds = v;
    @(negedge clk);
    cpu_wr   = 1'b0;
  endtask

  // Bounded wait for a transmit strobe, then check the byte.
  task automatic wait_tx(input string tag, input logic [7:0] exp, input int limit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (tx_start) found = 1'b1;
    end
    chk({tag, "_seen"}, 32'(found), 32'(1'b1));
    if (found) chk(tag, 32'(tx_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   first_err;

    rst = 1'b1; key_valid = 1'b0; key_code = '0; rx_valid = 1'b0; rx_data = '0;
    tx_ready = 1'b1; cpu_wr = 1'b0; cpu_leds = '0;
    tick(2);
    chk("rst_leds", 32'(leds), 32'(3'b000));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_tx_start", 32'(tx_start), 32'(1'b0));
    chk("rst_tx_data", 32'(tx_data), 32'(8'h00));
    chk("rst_err", 32'(err), 32'(1'b0));
    rst = 1'b0;
    tick(1);

    // Caps release is ignored.
    key(9'h114);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_start || busy) seen = 1'b1;
    end
    chk("release_ignored", 32'(seen), 32'(1'b0));

    // Caps press -> ED, FA -> 04, FA -> leds 100.
    key(9'h014);
    wait_tx("t1_cmd", 8'hED, 10);
    rx(8'hFA);
    wait_tx("t1_led", 8'h04, 10);
    rx(8'hFA);
    chk("t1_leds", 32'(leds), 32'(3'b100));
    tick(1);
    chk("t1_busy", 32'(busy), 32'(1'b0));

    // CPU write and Caps press in the same cycle: CPU value wins.
    cpu_wr = 1'b1; cpu_leds = 3'b011; key_valid = 1'b1; key_code = 9'h014;
    @(negedge clk);
    cpu_wr = 1'b0; key_valid = 1'b0;
    wait_tx("t2_cmd", 8'hED, 10);
    rx(8'hFA);
    wait_tx("t2_led", 8'h03, 10);
    rx(8'hFA);
    chk("t2_leds", 32'(leds), 32'(3'b011));

    // Transmitter busy for 50 cycles: no strobe until it frees up.
    tx_ready = 1'b0;
    cpu(3'b111);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    chk("t3_no_tx_while_not_ready", 32'(seen), 32'(1'b0));
    chk("t3_busy", 32'(busy), 32'(1'b1));
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t3_tx_start", 32'(tx_start), 32'(1'b1));
    chk("t3_tx_data", 32'(tx_data), 32'(8'hED));
    rx(8'hFA);
    wait_tx("t3_led", 8'h07, 10);
    rx(8'hFA);
    chk("t3_leds", 32'(leds), 32'(3'b111));

    // No ack: err exactly TO cycles after the ED strobe; target 111 -> 011.
    key(9'h014);
    wait_tx("t4_cmd", 8'hED, 10);
    first_err = 0;
    for (int k = 1; k <= TO + 5 && first_err == 0; k++) begin
      @(negedge clk);
      if (err) first_err = k;
    end
    chk("t4_err_cycle", 32'(first_err), 32'(TO));
    chk("t4_busy", 32'(busy), 32'(1'b0));
    chk("t4_leds_kept", 32'(leds), 32'(3'b111));
    @(negedge clk);
    chk("t4_err_pulse", 32'(err), 32'(1'b0));

    // Foreign byte ignored, then resend requests in WAIT_ACK2.
    cpu(3'b001);
    wait_tx("t5_cmd", 8'hED, 10);
    rx(8'hAA);
    chk("t5_ignored_busy", 32'(busy), 32'(1'b1));
    chk("t5_ignored_err", 32'(err), 32'(1'b0));
    rx(8'hFA);
    wait_tx("t5_led", 8'h01, 10);
`ifdef PS2_LED_RESEND_EN
    for (int r = 1; r <= MR; r++) begin
      rx(8'hFE);
      chk("t5_resend_no_err", 32'(err), 32'(1'b0));
      wait_tx("t5_resend_led", 8'h01, 10);
    end
`endif
    rx(8'hFE);
    chk("t5_fe_err", 32'(err), 32'(1'b1));
    tick(1);
    chk("t5_busy", 32'(busy), 32'(1'b0));
    chk("t5_leds_kept", 32'(leds), 32'(3'b111));

    // Caps press while waiting for the first ack: target 001 -> 101 -> 001.
    key(9'h014);
    wait_tx("t6_cmd_a", 8'hED, 10);
    key(9'h014);
    rx(8'hFA);
    wait_tx("t6_led_a", 8'h01, 10);
    rx(8'hFA);
    chk("t6_leds_a", 32'(leds), 32'(3'b001));
    wait_tx("t6_cmd_b", 8'hED, 10);
    rx(8'hFA);
    wait_tx("t6_led_b", 8'h01, 10);
    rx(8'hFA);
    tick(1);
    chk("t6_busy", 32'(busy), 32'(1'b0));

    // Reset while waiting for the LED-byte ack.
    key(9'h014);
    wait_tx("t7_cmd", 8'hED, 10);
    rx(8'hFA);
    wait_tx("t7_led", 8'h05, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_leds", 32'(leds), 32'(3'b000));
    chk("t7_busy", 32'(busy), 32'(1'b0));
    chk("t7_tx_data", 32'(tx_data), 32'(8'h00));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start || busy) seen = 1'b1;
    end
    chk("t7_quiet_after_rst", 32'(seen), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_led_ctrl.md
PS2_LED_CTRL -- requirements
Module: ps2_led_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, sets the cycles to wait for a keyboard response before abort (20 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 3, sets the resend attempts per byte; it is used only when PS2_LED_RESEND_EN is defined.
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 key_valid  in  1  one-cycle strobe; a decoded key event is present.
REQ-006 key_code  in  9  {released, char}; char 8'd20 is Caps Lock.
REQ-007 rx_valid  in  1  one-cycle strobe; a raw byte was received from the keyboard.
REQ-008 rx_data  in  8  raw received byte.
REQ-009 tx_ready  in  1  PS/2 transmitter idle; it can accept a byte.
REQ-010 tx_start  out  1  one-cycle strobe; transmit tx_data.
REQ-011 tx_data  out  8  byte to transmit.
REQ-012 cpu_wr  in  1  one-cycle CPU LED write strobe.
REQ-013 cpu_leds  in  3  CPU LED value {caps, num, scroll}.
REQ-014 leds  out  3  LED state last acknowledged by the keyboard.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err  out  1  one-cycle pulse on timeout, on non-ack, or when retries are exhausted.

Function
REQ-017 The block SHALL hold a 3-bit target register; a Caps Lock press (key_valid, key_code==9'h014) SHALL toggle target[2]; releases are ignored.
REQ-018 cpu_wr SHALL load target from cpu_leds; when cpu_wr and a Caps Lock press occur in the same cycle, cpu_wr SHALL win and the toggle SHALL be dropped.
REQ-019 Any target update SHALL set the pending flag; the pending flag SHALL clear on leaving IDLE.
REQ-020 FSM states SHALL be IDLE, SEND_CMD, WAIT_ACK1, SEND_LED, WAIT_ACK2.
REQ-021 From IDLE with pending set, the FSM SHALL move to SEND_CMD on the next cycle.
REQ-022 In SEND_CMD, when tx_ready is high, the block SHALL pulse tx_start for one cycle with tx_data=8'hED and move to WAIT_ACK1.
REQ-023 In WAIT_ACK1, rx 8'hFA SHALL move the FSM to SEND_LED.
REQ-024 In SEND_LED, the block SHALL latch target into the snapshot, pulse tx_start with tx_data={5'b0, snapshot}, and move to WAIT_ACK2.
REQ-025 In WAIT_ACK2, rx 8'hFA SHALL load leds with the snapshot and move the FSM to IDLE.
REQ-026 In the wait states, rx bytes other than 8'hFA and 8'hFE SHALL be ignored, and the FSM SHALL keep waiting.
REQ-027 The timeout counter SHALL clear on entry to each wait state; if it reaches TIMEOUT_CYCLES-1 with no ack, the block SHALL pulse err, go to IDLE, and leave leds unchanged.
REQ-028 If target changes while busy, the pending flag SHALL re-set, and a new sequence SHALL start after return to IDLE; tx_start SHALL never assert while tx_ready is low.
REQ-029 In a wait state, rx_valid SHALL take precedence over timeout expiry in the same cycle.

Reset
REQ-030 On rst the block SHALL go to IDLE with target, snapshot, leds, pending, counters, tx_start and err at 0, and tx_data at 8'h00.
REQ-031 A rst asserted mid-sequence SHALL abort the sequence with no further tx_start.

Configuration
REQ-032 With PS2_LED_RESEND_EN defined, rx 8'hFE in WAIT_ACK1 or WAIT_ACK2 SHALL return the FSM to SEND_CMD or SEND_LED respectively and increment the retry count (cleared on IDLE).
REQ-033 With PS2_LED_RESEND_EN defined, when the retry count reaches MAX_RETRY, the next 8'hFE SHALL pulse err and send the FSM to IDLE.
REQ-034 Without PS2_LED_RESEND_EN, rx 8'hFE SHALL pulse err and send the FSM to IDLE, and no retry logic SHALL be present.

Structure
REQ-035 Shared package ps2_pkg SHALL hold the constants PS2_CMD_SET_LED=8'hED, PS2_ACK=8'hFA, PS2_RESEND=8'hFE and KEY_CAPS=8'd20, the LED bit indices, and the FSM state enum.
REQ-036 Timeout counting SHALL be a sub-module ps2_timeout (clear, enable, expired), instantiated once.

Verification
REQ-037 Caps press -> tx 8'hED; FA -> tx 8'h04; FA -> leds=3'b100, busy=0.
REQ-038 cpu_wr cpu_leds=3'b011 with a Caps press in the same cycle -> tx 8'h03 sent; leds=3'b011 after the acks.
REQ-039 tx_ready held low 50 cycles -> no tx_start; tx_ready rises -> tx_start within 1 cycle.
REQ-040 No ack, TIMEOUT_CYCLES=100 -> err pulse at 100 cycles after ED, IDLE, leds unchanged.
REQ-041 8'hFE in WAIT_ACK2 -> with the macro, LED byte resent (4 FEs -> err); without the macro, immediate err.
REQ-042 Caps press during WAIT_ACK1 -> first sequence completes, then a second sequence sends the toggled value; rst in WAIT_ACK2 -> leds=0, IDLE.
